// File: rtl/instr_mem_loader_if.sv
// Boot byte stream from the image source into the instruction memory loader.
// Valid/ready: a byte moves on a rising clock edge where s_valid && s_ready; the source
// holds s_data/s_last stable while s_valid is high and s_ready is low.
interface instr_mem_loader_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/instr_mem_loader.sv
// Packs a little-endian boot byte stream into 32-bit instruction words and holds the core in
// reset until the image is complete. Optional macro CHECKSUM_WORD_EN: final word is a checksum.
module instr_mem_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  instr_mem_loader_if.slave    boot,
  input  logic [AW-1:0]        raddr,
  output logic [31:0]          rdata,
  output logic                 core_reset,
  output logic [AW:0]          word_count,
  output logic                 overflow,
  output logic                 error,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_DONE = 2'd1;
`ifdef CHECKSUM_WORD_EN
  localparam logic [1:0] S_ERROR = 2'd2;
`endif
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

  logic [1:0]    state;
  logic [1:0]    byte_idx;
  logic [23:0]   word_buf;
  logic [AW-1:0] wptr;
  logic [31:0]   cur_word;
  logic [31:0]   mem [DEPTH];
  logic          xfer;
  logic          word_end;
  logic          data_word;
  logic          at_cap;
  logic          do_write;
  logic          ovf_hit;

  assign boot.s_ready = (state == S_LOAD);
  assign xfer         = boot.s_valid && boot.s_ready;
  assign word_end     = xfer && ((byte_idx == 2'd3) || boot.s_last);
  assign at_cap       = (word_count == FULL);
  assign rdata        = mem[raddr];
  assign dbg_state    = state;

`ifdef CHECKSUM_WORD_EN
  // The word closed by s_last is the checksum, never a memory word.
  assign data_word = word_end && !boot.s_last;
`else
  assign data_word = word_end;
`endif
  assign do_write = data_word && !at_cap;
  assign ovf_hit  = data_word && at_cap;

  // Bytes not yet received are zero, which gives the padding of a short final word for free.
  always_comb begin
    cur_word = 32'd0;
    case (byte_idx)
      2'd0:    cur_word = {24'd0, boot.s_data};
      2'd1:    cur_word = {16'd0, boot.s_data, word_buf[7:0]};
      2'd2:    cur_word = {8'd0, boot.s_data, word_buf[15:0]};
      default: cur_word = {boot.s_data, word_buf};
    endcase
  end

  // Memory is deliberately outside the reset domain so a reset keeps the loaded image.
  always_ff @(posedge clock) begin
    if (do_write) mem[wptr] <= cur_word;
  end

`ifdef CHECKSUM_WORD_EN
  logic [31:0] sum;
  logic        error_q;
  assign error = error_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_LOAD;
      byte_idx   <= 2'd0;
      word_buf   <= 24'd0;
      wptr       <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      core_reset <= 1'b1;
      sum        <= 32'd0;
      error_q    <= 1'b0;
    end else if (xfer) begin
      byte_idx <= word_end ? 2'd0 : byte_idx + 2'd1;
      word_buf <= cur_word[23:0];
      if (do_write) begin
        wptr       <= wptr + 1'b1;
        word_count <= word_count + 1'b1;
        sum        <= sum + cur_word;
      end
      if (ovf_hit) overflow <= 1'b1;
      if (boot.s_last) begin
        if ((byte_idx == 2'd3) && !overflow && (cur_word == sum)) begin
          state      <= S_DONE;
          core_reset <= 1'b0;
        end else begin
          state   <= S_ERROR;
          error_q <= 1'b1;
        end
      end
    end
  end
`else
  assign error = 1'b0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_LOAD;
      byte_idx   <= 2'd0;
      word_buf   <= 24'd0;
      wptr       <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      core_reset <= 1'b1;
    end else if (xfer) begin
      byte_idx <= word_end ? 2'd0 : byte_idx + 2'd1;
      word_buf <= cur_word[23:0];
      if (do_write) begin
        wptr       <= wptr + 1'b1;
        word_count <= word_count + 1'b1;
      end
      if (ovf_hit) overflow <= 1'b1;
      if (boot.s_last) begin
        state      <= S_DONE;
        core_reset <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed and randomized boot images against a byte-list reference model of the loader.
module tb_instr_mem_loader;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  instr_mem_loader_if boot_if ();
  logic [AW-1:0] raddr;
  logic [31:0]   rdata;
  logic          core_reset;
  logic [AW:0]   word_count;
  logic          overflow;
  logic          error;
  logic [1:0]    dbg_state;

  instr_mem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock      (clk),
    .reset      (rst),
    .boot       (boot_if.slave),
    .raddr      (raddr),
    .rdata      (rdata),
    .core_reset (core_reset),
    .word_count (word_count),
    .overflow   (overflow),
    .error      (error),
    .dbg_state  (dbg_state)
  );

  // scoreboard
  logic [7:0]  byte_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_mem[DEPTH];
  bit          exp_known[DEPTH];
  int          exp_count;
  bit          exp_ovf;
  bit          exp_err;
  bit          exp_done;
  bit          exp_ready;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected effect of the bytes in byte_q, from the stream rules alone.
  task automatic model_stream(input bit with_last);
    int n, nw, ndata;
    logic [31:0] sum;
    logic [31:0] w;
    n  = byte_q.size();
    nw = (n + 3) / 4;
    exp_q.delete();
    for (int k = 0; k < nw; k++) begin
      w = 32'd0;
      for (int i = 4 * k; i < n && i < 4 * k + 4; i++)
        w = w | (32'(byte_q[i]) << (8 * (i % 4)));
      exp_q.push_back(w);
    end
    if (!with_last) ndata = n / 4;
`ifdef CHECKSUM_WORD_EN
    else ndata = nw - 1;
`else
    else ndata = nw;
`endif
    sum = 32'd0;
    for (int k = 0; k < ndata; k++) begin
      if (exp_count < DEPTH) begin
        exp_mem[exp_count]   = exp_q[k];
        exp_known[exp_count] = 1'b1;
        exp_count++;
        sum = sum + exp_q[k];
      end else begin
        exp_ovf = 1'b1;
      end
    end
    if (with_last) begin
      exp_ready = 1'b0;
`ifdef CHECKSUM_WORD_EN
      exp_done = (n % 4 == 0) && !exp_ovf && (exp_q[nw-1] == sum);
      exp_err  = !exp_done;
`else
      exp_done = 1'b1;
`endif
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    boot_if.s_valid = 1'b0;
    boot_if.s_last  = 1'b0;
    #2;
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_word_count", word_count, '0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_error", error, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0; exp_ovf = 0; exp_err = 0; exp_done = 0; exp_ready = 1;
    #1;
    chk("rst_s_ready", boot_if.s_ready, 1'b1);
  endtask

  // stall_mode 0: none, 1: idle cycle between bytes, 2: random idles
  task automatic run_image(input bit with_last, input int stall_mode, input string tag);
    int n, idles;
    n = byte_q.size();
    model_stream(with_last);
    for (int i = 0; i < n; i++) begin
      idles = (stall_mode == 1) ? (i > 0 ? 1 : 0) :
              (stall_mode == 2) ? ($urandom_range(3) == 0 ? $urandom_range(1, 3) : 0) : 0;
      boot_if.s_valid = 1'b0;
      boot_if.s_data  = 8'($urandom);
      boot_if.s_last  = 1'($urandom);
      repeat (idles) @(negedge clk);
      boot_if.s_valid = 1'b1;
      boot_if.s_data  = byte_q[i];
      boot_if.s_last  = with_last && (i == n - 1);
      if (boot_if.s_last) chk({tag, "_core_reset_pre"}, core_reset, 1'b1);
      @(negedge clk);
    end
    boot_if.s_valid = 1'b0;
    boot_if.s_last  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_word_count"}, word_count, 32'(exp_count));
    chk({tag, "_overflow"}, overflow, exp_ovf);
    chk({tag, "_error"}, error, exp_err);
    chk({tag, "_core_reset"}, core_reset, !exp_done);
    chk({tag, "_s_ready"}, boot_if.s_ready, exp_ready);
    for (int a = 0; a < DEPTH; a++) begin
      if (exp_known[a]) begin
        raddr = AW'(a);
        #1;
        chk($sformatf("%s_mem%0d", tag, a), rdata, exp_mem[a]);
      end
    end
  endtask

  task automatic read_word(input int a, output logic [31:0] v);
    raddr = AW'(a);
    #1;
    v = rdata;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] s;
    int nw;
    n_checks = 0; n_fail = 0;
    rst = 1'b1;
    boot_if.s_valid = 1'b0; boot_if.s_data = 8'd0; boot_if.s_last = 1'b0;
    raddr = '0;
    for (int a = 0; a < DEPTH; a++) exp_known[a] = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // single word image
    byte_q = '{8'h0D, 8'h00, 8'h00, 8'h00};
    run_image(1'b1, 0, "img0d");
    check_all("img0d");
`ifndef CHECKSUM_WORD_EN
    read_word(0, v);
    chk("img0d_const", v, 32'h0000000D);
`endif

    // alternating valid
    do_reset();
    byte_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_image(1'b1, 1, "toggle");
    check_all("toggle");
`ifndef CHECKSUM_WORD_EN
    read_word(1, v);
    chk("toggle_const1", v, 32'h08070605);
`endif

    // partial final word
    do_reset();
    byte_q = '{8'hAA, 8'hBB};
    run_image(1'b1, 0, "partial");
    check_all("partial");
`ifndef CHECKSUM_WORD_EN
    read_word(0, v);
    chk("partial_const", v, 32'h0000BBAA);
`endif

    // overflow: one word more than the memory holds
    do_reset();
    byte_q.delete();
    for (int i = 0; i < 4 * (DEPTH + 1); i++) byte_q.push_back(8'($urandom));
    run_image(1'b1, 2, "ovf");
    check_all("ovf");

    // reset in the middle of an image drops the partial word
    do_reset();
    byte_q.delete();
    for (int i = 0; i < 6; i++) byte_q.push_back(8'($urandom));
    run_image(1'b0, 0, "abort");
    check_all("abort");
    do_reset();
    byte_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_image(1'b1, 0, "restart");
    check_all("restart");
`ifndef CHECKSUM_WORD_EN
    read_word(0, v);
    chk("restart_const", v, 32'h44332211);
`endif

`ifdef CHECKSUM_WORD_EN
    do_reset();
    byte_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    run_image(1'b1, 0, "csum_ok");
    check_all("csum_ok");
    chk("csum_ok_count_const", word_count, 32'd2);
    do_reset();
    byte_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
    run_image(1'b1, 0, "csum_bad");
    check_all("csum_bad");
    chk("csum_bad_error_const", error, 1'b1);
`endif

    // random images, some with a valid checksum word appended
    for (int it = 0; it < 12; it++) begin
      do_reset();
      byte_q.delete();
      if ($urandom_range(1) == 0) begin
        nw = $urandom_range(1, DEPTH + 2);
        s  = 32'd0;
        for (int k = 0; k < nw; k++) begin
          v = $urandom;
          if (k < DEPTH) s = s + v;
          for (int b = 0; b < 4; b++) byte_q.push_back(v[8*b +: 8]);
        end
        for (int b = 0; b < 4; b++) byte_q.push_back(s[8*b +: 8]);
      end else begin
        nw = $urandom_range(1, 4 * DEPTH + 6);
        for (int i = 0; i < nw; i++) byte_q.push_back(8'($urandom));
      end
      run_image(1'b1, 2, $sformatf("rnd%0d", it));
      check_all($sformatf("rnd%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256, instruction-word capacity, power of two, range 2..256.
REQ-002 SHALL have parameter AW, default 8, word address width, equal to log2(DEPTH).
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-005 SHALL have port s_valid, input, 1 bit: the boot byte on s_data is valid.
REQ-006 SHALL have port s_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-007 SHALL have port s_data, input, 8 bits: boot stream byte.
REQ-008 SHALL have port s_last, input, 1 bit: marks the final byte of the image.
REQ-009 SHALL have port raddr, input, AW bits: core instruction word address.
REQ-010 SHALL have port rdata, output, 32 bits: instruction word at raddr.
REQ-011 SHALL have port core_reset, output, 1 bit: holds the downstream core in reset.
REQ-012 SHALL have port word_count, output, AW+1 bits: number of words written to memory.
REQ-013 SHALL have port overflow, output, 1 bit: the image exceeded DEPTH words.
REQ-014 SHALL have port error, output, 1 bit: checksum failure (see Configuration).

Function
REQ-015 SHALL implement states LOAD, DONE and ERROR; reset enters LOAD.
REQ-016 s_ready SHALL be 1 in LOAD and 0 in DONE and ERROR; a byte transfers when s_valid && s_ready.
REQ-017 SHALL assemble bytes little-endian: byte k of a word goes to bits [8k+7:8k], k = 0..3.
REQ-018 On the 4th byte of a word, SHALL write the word to mem[wptr], increment wptr and increment word_count, all on the same edge.
REQ-019 SHALL set overflow when a word completes with word_count == DEPTH, discard that word, and leave memory and word_count unchanged.
REQ-020 s_last on byte k < 3 SHALL zero-pad the remaining bytes and write the partial word.
REQ-021 A transfer carrying s_last SHALL move the loader LOAD -> DONE on the same edge.
REQ-022 s_last on the first byte of an otherwise empty stream SHALL write a single zero-padded word.
REQ-023 core_reset SHALL be 1 in LOAD and ERROR and 0 in DONE, registered; first deasserted the cycle after the s_last transfer.
REQ-024 rdata SHALL be combinational mem[raddr] in every state, with no write bypass; a same-cycle write is visible the next cycle.
REQ-025 DONE and ERROR SHALL be terminal; only reset leaves them.
REQ-026 Stalls (s_valid = 0) SHALL preserve byte position and the partial word indefinitely.

Reset
REQ-027 Asserting reset SHALL immediately force: state LOAD, byte index 0, wptr 0, word_count 0, overflow 0, error 0, core_reset 1, s_ready 1 (after release).
REQ-028 Reset SHALL NOT clear memory contents; a reset mid-load SHALL discard any partial word.

Configuration
REQ-029 With CHECKSUM_WORD_EN defined, the word completed with s_last SHALL NOT be written to memory; it SHALL be compared to the mod-2^32 sum of all written words.
REQ-030 Under CHECKSUM_WORD_EN, a checksum match SHALL enter DONE; a mismatch, a partial final word, or overflow at s_last SHALL enter ERROR with error = 1.
REQ-031 Without CHECKSUM_WORD_EN, the final word SHALL be written like any other, ERROR SHALL be unreachable, and error SHALL be tied to 0.

Verification
REQ-032 Stream bytes 0D,00,00,00 with s_last on the last byte -> mem[0] = 0000000D, word_count = 1; core_reset falls one cycle later.
REQ-033 8 bytes 01..08 with s_valid toggling 1/0 every cycle -> mem[0] = 04030201, mem[1] = 08070605, s_ready 0 after the s_last transfer.
REQ-034 Bytes AA,BB with s_last on BB -> mem[0] = 0000BBAA, word_count = 1, state DONE.
REQ-035 DEPTH+1 full words, s_last on the final byte -> overflow = 1, word_count = DEPTH, mem[0] still holds word 0.
REQ-036 Reset pulse after 6 of 8 bytes, then a new 4-byte image 11,22,33,44 -> mem[0] = 44332211, word_count = 1, no stale partial bytes.
REQ-037 CHECKSUM_WORD_EN: words 00000001, 00000002 + checksum 00000003 -> DONE, word_count = 2; checksum 00000004 -> error = 1, core_reset stays 1.
